// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation run-control / memory-dump sequencer.
package sim_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DUMP,
    DONE
  } state_t;

endpackage

// File: rtl/sim_dump_fifo.sv
// Two-entry output buffer of {index, last, data}; absorbs the one-cycle RAM
// latency and consumer back-pressure so reads can be issued back to back.
module sim_dump_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_index,
  input  logic                  push_last,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [ADDR_WIDTH-1:0] head_index,
  output logic                  head_last,
  output logic [DATA_WIDTH-1:0] head_data
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  ent_t mem [2];
  logic wp, rp;
  logic wr_ok, rd_ok;

  assign rd_ok = pop && (count != 2'd0);
  assign wr_ok = push && ((count != 2'd2) || rd_ok);

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= '{idx: push_index, last: push_last, data: push_data};
        wp      <= ~wp;
      end
      if (rd_ok) rp <= ~rp;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_index = mem[rp].idx;
  assign head_last  = mem[rp].last;
  assign head_data  = mem[rp].data;

endmodule

// File: rtl/sim_run_dump_ctrl.sv
// Gates the CPU for one run (halt or cycle budget), waits for stores to drain,
// then streams a window of data RAM out as a valid/ready word stream.
module sim_run_dump_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 9,
  parameter int unsigned DUMP_BASE    = 0,
  parameter int unsigned DUMP_WORDS   = 512,
  parameter int unsigned MAX_CYCLES   = 5000,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter bit          HALT_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  output logic                  cpu_enable,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_index,
  output logic                  dump_last,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int CW1 = CNT_W + 1;
  localparam int IW  = $clog2(DUMP_WORDS + 1);
  localparam logic [CW1-1:0] MAXC = CW1'(MAX_CYCLES);

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cyc;
  logic [CW1-1:0]        cyc_nx;
  logic                  to_q;
  int unsigned           drain_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr, pend_addr;
  logic [IW-1:0]         issued;
  logic                  pend, pend_last;
  logic                  halt_hit, budget_hit, pop, issue, f_last;
  logic [1:0]            f_cnt, in_use;

  assign cyc_nx     = {1'b0, cyc} + 1'b1;
  assign halt_hit   = HALT_EN && halt;
  assign budget_hit = (cyc_nx == MAXC);

  // A word popped this cycle frees its slot for a read issued this cycle.
  assign pop    = dump_valid && dump_ready;
  assign in_use = f_cnt + {1'b0, pend} - {1'b0, pop};
  assign issue  = (state == DUMP) && (issued != IW'(DUMP_WORDS)) && (in_use < 2'd2);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (halt_hit || budget_hit) state_nx = (DRAIN_CYCLES == 0) ? DUMP : DRAIN;
      DRAIN:      if (drain_cnt + 1 >= DRAIN_CYCLES) state_nx = DUMP;
      DUMP:       if (pop && f_last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cyc       <= '0;
      to_q      <= 1'b0;
      drain_cnt <= 0;
      rd_addr   <= '0;
      issued    <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_last <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= issue;
      case (state)
        IDLE, DONE: if (start) begin
          cyc       <= '0;
          to_q      <= 1'b0;
          drain_cnt <= 0;
          rd_addr   <= ADDR_WIDTH'(DUMP_BASE);
          issued    <= '0;
        end
        RUN: begin
          if (cyc != '1) cyc <= cyc + 1'b1;
          if (budget_hit && !halt_hit) to_q <= 1'b1;
        end
        DRAIN: drain_cnt <= drain_cnt + 1;
        DUMP: if (issue) begin
          rd_addr   <= rd_addr + 1'b1;
          issued    <= issued + 1'b1;
          pend_addr <= rd_addr;
          pend_last <= (issued == IW'(DUMP_WORDS - 1));
        end
        default: ;
      endcase
    end
  end

  sim_dump_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pend),
    .push_index(pend_addr),
    .push_last (pend_last),
    .push_data (mem_rd_data),
    .pop       (pop),
    .count     (f_cnt),
    .head_index(dump_index),
    .head_last (f_last),
    .head_data (dump_data)
  );

  assign dump_valid  = (f_cnt != 2'd0);
  assign dump_last   = f_last && dump_valid;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_addr;
  assign cpu_enable  = (state == RUN);
  assign busy        = (state == RUN) || (state == DRAIN) || (state == DUMP);
  assign done        = (state == DONE);
  assign timed_out   = to_q;
  assign cycle_count = cyc;

endmodule

// File: tb/tb_sim_run_dump_ctrl.sv
// Scoreboard bench: instance a (halt-driven, 8 words, drain 8) and instance b
// (timeout-only, 4-bit address wrap, no drain).
module tb_sim_run_dump_ctrl;

  typedef struct {
    logic [8:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a signals
  logic        a_start = 0, a_halt = 0, a_rdy = 1, a_en, a_rd_en, a_dv, a_last, a_busy, a_done, a_to;
  logic [8:0]  a_raddr, a_idx;
  logic [31:0] a_rdata = 0, a_data, a_cnt;
  // instance b signals
  logic        b_start = 0, b_halt = 1, b_rdy = 1, b_en, b_rd_en, b_dv, b_last, b_busy, b_done, b_to;
  logic [3:0]  b_raddr, b_idx;
  logic [31:0] b_rdata = 0, b_data, b_cnt;

  sim_run_dump_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DUMP_BASE(0), .DUMP_WORDS(8),
                      .MAX_CYCLES(50), .DRAIN_CYCLES(8), .HALT_EN(1'b1)) dut_a (
    .clk(clk), .reset(rst_n), .start(a_start), .halt(a_halt), .cpu_enable(a_en),
    .mem_rd_en(a_rd_en), .mem_rd_addr(a_raddr), .mem_rd_data(a_rdata),
    .dump_valid(a_dv), .dump_ready(a_rdy), .dump_data(a_data), .dump_index(a_idx),
    .dump_last(a_last), .busy(a_busy), .done(a_done), .timed_out(a_to), .cycle_count(a_cnt));

  sim_run_dump_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DUMP_BASE(14), .DUMP_WORDS(4),
                      .MAX_CYCLES(30), .DRAIN_CYCLES(0), .HALT_EN(1'b0)) dut_b (
    .clk(clk), .reset(rst_n), .start(b_start), .halt(b_halt), .cpu_enable(b_en),
    .mem_rd_en(b_rd_en), .mem_rd_addr(b_raddr), .mem_rd_data(b_rdata),
    .dump_valid(b_dv), .dump_ready(b_rdy), .dump_data(b_data), .dump_index(b_idx),
    .dump_last(b_last), .busy(b_busy), .done(b_done), .timed_out(b_to), .cycle_count(b_cnt));

  int n_chk = 0, n_fail = 0;
  exp_t qa[$], qb[$];
  int en_a, busy_a, iss_a, acc_a, en_b, busy_b;
  bit bp = 0;
  int ph = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // RAM models: one-cycle read latency, garbage when not read.
  initial forever begin
    @(posedge clk);
    a_rdata <= a_rd_en ? 32'h100 + 32'(a_raddr) : 32'hdeadbeef;
    b_rdata <= b_rd_en ? 32'h200 + 32'(b_raddr) : 32'hdeadbeef;
  end

  // back-pressure pattern 1,0,0 when enabled
  initial forever begin
    @(posedge clk); #1;
    if (bp) begin a_rdy = (ph == 0); ph = (ph + 1) % 3; end
    else a_rdy = 1'b1;
  end

  logic        stall_a = 0;
  logic [42:0] held_a = '0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (a_en) en_a++;
      if (a_busy) busy_a++;
      if (a_rd_en) iss_a++;
      if (stall_a) check("a_hold", 64'({a_dv, a_idx, a_last, a_data}), 64'(held_a));
      if (a_dv && a_rdy) begin
        acc_a++;
        if (qa.size() == 0) check("a_extra_word", 64'(a_idx), 64'h1ff_ffff);
        else begin
          e = qa.pop_front();
          check("a_idx", 64'(a_idx), 64'(e.idx));
          check("a_data", 64'(a_data), 64'(e.data));
          check("a_last", 64'(a_last), 64'(e.last));
        end
      end
      if (a_rd_en) check("a_credit", 64'(iss_a - acc_a <= 2), 64'd1);
      stall_a = a_dv && !a_rdy;
      held_a  = {a_dv, a_idx, a_last, a_data};
      if (b_en) en_b++;
      if (b_busy) busy_b++;
      if (b_dv && b_rdy) begin
        if (qb.size() == 0) check("b_extra_word", 64'(b_idx), 64'hffff);
        else begin
          e = qb.pop_front();
          check("b_idx", 64'(b_idx), 64'(e.idx));
          check("b_data", 64'(b_data), 64'(e.data));
          check("b_last", 64'(b_last), 64'(e.last));
        end
      end
    end
  end

  task automatic wait_done_a();
    for (int i = 0; i < 3000 && a_done !== 1'b1; i++) @(negedge clk);
    check("a_done", 64'(a_done), 64'd1);
  endtask

  // Entered at posedge+1; returns at posedge+1.
  task automatic run_a(input int halt_at, input int exp_cnt, input bit exp_to,
                       input bit bpm, input int exp_busy);
    bp = bpm;
    for (int i = 0; i < 8; i++)
      qa.push_back('{idx: 9'(i), data: 32'h100 + 32'(i), last: (i == 7)});
    en_a = 0; busy_a = 0; iss_a = 0; acc_a = 0;
    if (halt_at == 1) a_halt = 1;
    a_start = 1;
    @(posedge clk); #1 a_start = 0;
    check("a_done_clr", 64'(a_done), 64'd0);
    check("a_to_clr", 64'(a_to), 64'd0);
    check("a_cnt_clr", 64'(a_cnt), 64'd0);
    if (halt_at > 1) begin
      repeat (halt_at - 1) @(posedge clk);
      #1 a_halt = 1;
    end
    wait_done_a();
    a_halt = 0;
    check("a_cycle_count", 64'(a_cnt), 64'(exp_cnt));
    check("a_timed_out", 64'(a_to), 64'(exp_to));
    check("a_en_cycles", 64'(en_a), 64'(exp_cnt));
    check("a_idle_outs", 64'({a_en, a_busy, a_dv}), 64'd0);
    check("a_words_left", 64'(qa.size()), 64'd0);
    if (exp_busy > 0) check("a_busy_cycles", 64'(busy_a), 64'(exp_busy));
    bp = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_outs", 64'({a_en, a_rd_en, a_dv, a_last, a_busy, a_done, a_to}), 64'd0);
    check("rst_a_cnt", 64'(a_cnt), 64'd0);
    check("rst_b_outs", 64'({b_en, b_rd_en, b_dv, b_busy, b_done, b_to}), 64'd0);
    rst_n = 1;
    @(posedge clk); #1;

    run_a(20, 20, 0, 0, 20 + 8 + 10);
    run_a(0, 50, 1, 0, 50 + 8 + 10);
    run_a(50, 50, 0, 0, 50 + 8 + 10);
    run_a(1, 1, 0, 0, 1 + 8 + 10);
    run_a(10, 10, 0, 1, 0);

    // reset in the middle of a dump, after two words
    for (int i = 0; i < 8; i++)
      qa.push_back('{idx: 9'(i), data: 32'h100 + 32'(i), last: (i == 7)});
    a_start = 1;
    @(posedge clk); #1 a_start = 0;
    repeat (4) @(posedge clk);
    #1 a_halt = 1;
    for (int i = 0; i < 200 && qa.size() > 6; i++) @(negedge clk);
    check("a_two_words", 64'(qa.size() <= 6), 64'd1);
    @(posedge clk); #1 rst_n = 0; a_halt = 0;
    @(posedge clk); #1 rst_n = 1;
    check("mid_rst_outs", 64'({a_en, a_rd_en, a_dv, a_last, a_busy, a_done, a_to}), 64'd0);
    check("mid_rst_cnt", 64'(a_cnt), 64'd0);
    check("mid_rst_data", 64'({a_data, a_idx, a_raddr}), 64'd0);
    qa.delete();
    repeat (2) @(negedge clk);
    check("mid_rst_no_stale", 64'({a_dv, a_busy}), 64'd0);
    @(posedge clk); #1;
    run_a(20, 20, 0, 0, 20 + 8 + 10);

    // timeout-only instance with address wrap; halt held high, stray start mid-run
    for (int i = 0; i < 4; i++)
      qb.push_back('{idx: 9'((14 + i) % 16), data: 32'h200 + 32'((14 + i) % 16), last: (i == 3)});
    en_b = 0; busy_b = 0;
    b_start = 1;
    @(posedge clk); #1 b_start = 0;
    repeat (9) @(posedge clk);
    #1 b_start = 1;
    @(posedge clk); #1 b_start = 0;
    for (int i = 0; i < 500 && b_done !== 1'b1; i++) @(negedge clk);
    check("b_done", 64'(b_done), 64'd1);
    check("b_cycle_count", 64'(b_cnt), 64'd30);
    check("b_timed_out", 64'(b_to), 64'd1);
    check("b_en_cycles", 64'(en_b), 64'd30);
    check("b_busy_cycles", 64'(busy_b), 64'(30 + 0 + 6));
    check("b_words_left", 64'(qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
